// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
//   op_t    : decoded view of the 3-bit op field {is_div, is_unsigned, sel_hi}
//   state_t : sequencer states IDLE -> PREP -> CALC -> FIX -> DONE
package muldiv_pkg;

  // Bit positions inside the op field.
  localparam int unsigned OP_SEL_HI      = 0;
  localparam int unsigned OP_IS_UNSIGNED = 1;
  localparam int unsigned OP_IS_DIV      = 2;

  typedef struct packed {
    logic is_div;       // 1: div/mod, 0: mul/muh
    logic is_unsigned;  // 1: unsigned operands
    logic sel_hi;       // 1: high product half / remainder
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
//   is_div : selects compare-subtract-shift (1) or add-shift (0)
//   acc    : accumulator (mul high half) / partial remainder (div)
//   lo     : multiplier being consumed (mul) / dividend turning into quotient (div)
//   mag    : multiplicand (mul) / divisor (div), both as unsigned magnitudes
//   acc_nx, lo_nx : register values after this iteration
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] mag,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] lo_nx
);

  logic [WIDTH:0]   sum;    // mul: acc + mcand with carry kept
  logic [WIDTH:0]   sel;    // mul: value shifted down into {acc, lo}
  logic [WIDTH:0]   sh;     // div: {rem, quo[MSB]}
  logic [WIDTH-1:0] diff;   // div: sh - divisor, only meaningful when sh >= divisor
  logic             ge;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, mag};
    sel  = lo[0] ? sum : {1'b0, acc};
    sh   = {acc, lo[WIDTH-1]};
    ge   = (sh >= {1'b0, mag});
    // When sh >= divisor the difference is below the divisor, so it fits in WIDTH bits.
    diff = sh[WIDTH-1:0] - mag;

    acc_nx = '0;
    lo_nx  = '0;
    if (is_div) begin
      if (ge) begin
        acc_nx = diff;
        lo_nx  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = sh[WIDTH-1:0];
        lo_nx  = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = sel[WIDTH:1];
      lo_nx  = {sel[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer for mul/muh/mulu/muhu and div/mod/divu/modu.
// Fixed latency: WIDTH+3 cycles from accepted start to the one-cycle done.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, sampled only in IDLE
//   op         : {is_div, is_unsigned, sel_hi}
//   a, b       : operands, captured with start
//   cancel     : abort an operation in flight (no effect in DONE)
//   busy       : state != IDLE
//   stall      : holds the core until the result is presented
//   done       : high for the single DONE cycle
//   result     : result, loaded in FIX and held afterwards
//   div_zero   : divide by zero flag, loaded with result
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc, lo, mag;
  logic             sign_q, sign_r;

  logic             is_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc_nx, lo_nx;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;
  logic               b_zero, fix_dz;

  function automatic logic [WIDTH-1:0] abs_of(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_q.is_div),
    .acc    (acc),
    .lo     (lo),
    .mag    (mag),
    .acc_nx (acc_nx),
    .lo_nx  (lo_nx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start && !cancel) state_nx = S_PREP;
      S_PREP: state_nx = cancel ? S_IDLE : S_CALC;
      S_CALC: begin
        if (cancel)               state_nx = S_IDLE;
        else if (cnt == LAST_CNT) state_nx = S_FIX;
      end
      S_FIX:  state_nx = cancel ? S_IDLE : S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    stall = ((state == S_IDLE) && start && !cancel) ||
            (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  end

  // Operand magnitudes formed in PREP from the captured operands
  always_comb begin
    is_signed = !op_q.is_unsigned;
    a_mag     = abs_of(a_q, is_signed);
    b_mag     = abs_of(b_q, is_signed);
  end

  // Sign fix-up and result selection evaluated during FIX
  always_comb begin
    b_zero   = (b_q == '0);
    prod     = {acc, lo};
    prod_fix = sign_q ? -prod : prod;
    quo_fix  = sign_q ? -lo : lo;
    rem_fix  = sign_r ? -acc : acc;
    // Divide by zero: CALC still ran, its output is replaced here.
    if (op_q.is_div && b_zero) begin
      quo_fix = ALL_ONES;
      rem_fix = a_q;
    end
    fix_dz = op_q.is_div && b_zero;
    if (op_q.is_div) fix_result = op_q.sel_hi ? rem_fix : quo_fix;
    else             fix_result = op_q.sel_hi ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      lo       <= '0;
      mag      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            op_q <= op_t'(op);
            a_q  <= a;
            b_q  <= b;
          end
        end
        S_PREP: begin
          // Multiply consumes b bit by bit; divide shifts a into the remainder.
          lo     <= op_q.is_div ? a_mag : b_mag;
          mag    <= op_q.is_div ? b_mag : a_mag;
          acc    <= '0;
          cnt    <= '0;
          sign_q <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= is_signed && a_q[WIDTH-1];
        end
        S_CALC: begin
          acc <= acc_nx;
          lo  <= lo_nx;
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (!cancel) begin
            result   <= fix_result;
            div_zero <= fix_dz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq (WIDTH=32): directed vectors, randomized ops against an
// arithmetic reference model, cancel, start-while-busy and mid-operation reset.
module tb_muldiv_seq;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 3;
  localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         cancel;
  logic         busy, stall, done, div_zero;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Reference: {div_zero, result} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    logic [W-1:0]    q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (!o[2]) begin
      if (o[1]) p = ux * uy;
      else      p = sx * sy;
      return {1'b0, o[0] ? p[63:32] : p[31:0]};
    end
    if (y == '0) return {1'b1, o[0] ? x : 32'hFFFF_FFFF};
    if (o[1]) begin
      q = W'(ux / uy);
      r = W'(ux % uy);
    end else if (x == MIN_INT && y == 32'hFFFF_FFFF) begin
      q = MIN_INT;
      r = '0;
    end else begin
      q = W'(sx / sy);
      r = W'(sx % sy);
    end
    return {1'b0, o[0] ? r : q};
  endfunction

  // Drives one operation starting in an IDLE cycle and waits (bounded) for done.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit hold, output logic [W-1:0] res, output logic dz,
                       output int lat, output int stall_bad);
    stall_bad = 0;
    lat = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    if (stall !== 1'b1) stall_bad++;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (!hold) start = 1'b0;
      op = 3'($urandom); a = $urandom; b = $urandom;
      if (done === 1'b1) break;
      if (stall !== 1'b1 || busy !== 1'b1) stall_bad++;
    end
    start = 1'b0;
    if (stall !== 1'b0) stall_bad++;
    res = result;
    dz  = div_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, stall, div_zero} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b stall=%b dz=%b result=%h required all zero",
               busy, done, stall, div_zero, result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]   vo [10] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b100, 3'b101};
    logic [W-1:0] va [10] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'h1234, 32'h1234, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [W-1:0] vb [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 32'd2, 32'd2,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [W-1:0] er [10] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic         ed [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] res;
    logic         dz;
    int           lat, sb;
    for (int i = 0; i < 10; i++) begin
      do_op(vo[i], va[i], vb[i], 1'b0, res, dz, lat, sb);
      checks++;
      if (res !== er[i] || dz !== ed[i]) begin
        errors++;
        $display("FAIL directed[%0d] op=%b: result=%h dz=%b required result=%h dz=%b",
                 i, vo[i], res, dz, er[i], ed[i]);
      end
      checks++;
      if (lat != LAT || sb != 0) begin
        errors++;
        $display("FAIL directed_timing[%0d]: latency=%0d stall_errs=%0d required latency=%0d stall_errs=0",
                 i, lat, sb, LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] x, y, res;
    logic         dz;
    logic [W:0]   exp;
    int           lat, sb;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = '0;
        1: begin x = MIN_INT; y = 32'hFFFF_FFFF; end
        2: x = MIN_INT;
        3: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp = model(o, x, y);
      do_op(o, x, y, 1'b0, res, dz, lat, sb);
      checks++;
      if ({dz, res} !== exp || lat != LAT || sb != 0) begin
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: dz=%b result=%h lat=%0d stall_errs=%0d required dz=%b result=%h lat=%0d",
                 i, o, x, y, dz, res, lat, sb, exp[W], exp[W-1:0], LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res;
    logic         dz;
    int           lat, sb;
    // Start held high through the whole operation must not be queued or restart it.
    do_op(3'b010, 32'd1000, 32'd3, 1'b1, res, dz, lat, sb);
    checks++;
    if (res !== 32'd3000 || lat != LAT || sb != 0) begin
      errors++;
      $display("FAIL start_held: result=%h lat=%0d stall_errs=%0d required result=%h lat=%0d",
               res, lat, sb, 32'd3000, LAT);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result !== 32'd3000) begin
      errors++;
      $display("FAIL idle_after_done: busy=%b result=%h required busy=0 result=%h", busy, result, 32'd3000);
    end
    // Two operations issued in consecutive IDLE-after-DONE cycles.
    do_op(3'b110, 32'd100, 32'd7, 1'b0, res, dz, lat, sb);
    do_op(3'b111, 32'd100, 32'd7, 1'b0, res, dz, lat, sb);
    checks++;
    if (res !== 32'd2 || dz !== 1'b0 || lat != LAT) begin
      errors++;
      $display("FAIL back_to_back: result=%h dz=%b lat=%0d required result=%h dz=0 lat=%0d",
               res, dz, lat, 32'd2, LAT);
    end
  endtask

  task automatic test_cancel();
    logic [W-1:0] prev;
    int           seen;
    @(posedge clk); #1;
    prev = result;
    start = 1'b1; op = 3'b000; a = 32'd12345; b = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
      errors++;
      $display("FAIL cancel_calc: busy=%b done=%b result=%h required busy=0 done=0 result=%h",
               busy, done, result, prev);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || result !== prev) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL cancel_no_done: bad_cycles=%0d required 0", seen);
    end
    // cancel together with start in IDLE keeps the sequencer idle.
    start = 1'b1; cancel = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL cancel_start_stall: stall=%b required 0", stall);
    end
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_start_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b011; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, stall, div_zero} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b stall=%b dz=%b result=%h required all zero",
               busy, done, stall, div_zero, result);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: active_cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
